// File: rtl/slave_req_dispatcher_if.sv
// rtl/slave_req_dispatcher_if.sv - master/slave request bundle around one slave_req_dispatcher
interface slave_req_dispatcher_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              m0_req;
   logic              m0_cmd;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata;
   logic              m0_ack;
   logic              m1_req;
   logic              m1_cmd;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata;
   logic              m1_ack;
   logic              s_req;
   logic              s_cmd;
   logic [ADDR_W-1:0] s_addr;
   logic [DATA_W-1:0] s_wdata;
   logic              s_ack;
   logic              data_read0;
   logic              data_read1;
   logic [1:0]        stat0;
   logic [1:0]        stat1;

   modport slave (
      input  m0_req, m0_cmd, m0_addr, m0_wdata,
      input  m1_req, m1_cmd, m1_addr, m1_wdata,
      input  s_ack, data_read0, data_read1,
      output m0_ack, m1_ack, s_req, s_cmd, s_addr, s_wdata, stat0, stat1
   );

   modport master (
      output m0_req, m0_cmd, m0_addr, m0_wdata,
      output m1_req, m1_cmd, m1_addr, m1_wdata,
      output s_ack, data_read0, data_read1,
      input  m0_ack, m1_ack, s_req, s_cmd, s_addr, s_wdata, stat0, stat1
   );
endinterface

// File: rtl/slave_req_dispatcher.sv
// rtl/slave_req_dispatcher.sv - per-slave arbiter/forwarder for two masters with status codes
// RR_ARB_EN: round-robin between contending masters; otherwise master0 has fixed priority.
module slave_req_dispatcher #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter bit S_NO   = 1'b0
) (
   input logic                   clk,
   input logic                   reset,
   slave_req_dispatcher_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, RDWAIT = 2'd2} state_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WACK  = 2'd1;
   localparam logic [1:0] ST_WDATA = 2'd3;

   state_t              r_state;
   logic                r_gnt;
   logic                r_s_req;
   logic                r_s_cmd;
   logic [ADDR_W-1:0]   r_s_addr;
   logic [DATA_W-1:0]   r_s_wdata;
   logic                r_m0_ack;
   logic                r_m1_ack;
   logic [1:0]          r_stat0;
   logic [1:0]          r_stat1;
   logic                w_elig0;
   logic                w_elig1;
   logic                w_pick;
   logic                w_data_read;

   assign w_elig0     = bus.m0_req && (bus.m0_addr[ADDR_W-1] == S_NO);
   assign w_elig1     = bus.m1_req && (bus.m1_addr[ADDR_W-1] == S_NO);
   assign w_data_read = r_gnt ? bus.data_read1 : bus.data_read0;

`ifdef RR_ARB_EN
   logic r_last_grant;
   // Under contention the master that did not win last time goes first.
   assign w_pick = (w_elig0 && w_elig1) ? ~r_last_grant : w_elig1;
`else
   assign w_pick = !w_elig0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_gnt     <= 1'b0;
         r_s_req   <= 1'b0;
         r_s_cmd   <= 1'b0;
         r_s_addr  <= '0;
         r_s_wdata <= '0;
         r_m0_ack  <= 1'b0;
         r_m1_ack  <= 1'b0;
         r_stat0   <= ST_IDLE;
         r_stat1   <= ST_IDLE;
`ifdef RR_ARB_EN
         r_last_grant <= 1'b1;
`endif
      end else begin
         r_m0_ack <= 1'b0;
         r_m1_ack <= 1'b0;
         case (r_state)
            IDLE: if (w_elig0 || w_elig1) begin
               r_gnt     <= w_pick;
               r_s_req   <= 1'b1;
               r_s_cmd   <= w_pick ? bus.m1_cmd   : bus.m0_cmd;
               r_s_addr  <= w_pick ? bus.m1_addr  : bus.m0_addr;
               r_s_wdata <= w_pick ? bus.m1_wdata : bus.m0_wdata;
               if (w_pick) r_stat1 <= ST_WACK;
               else        r_stat0 <= ST_WACK;
`ifdef RR_ARB_EN
               r_last_grant <= w_pick;
`endif
               r_state <= GRANT;
            end
            // The ack is owed even if the winner has dropped req meanwhile.
            GRANT: if (bus.s_ack) begin
               r_s_req <= 1'b0;
               if (r_gnt) begin
                  r_m1_ack <= 1'b1;
                  r_stat1  <= r_s_cmd ? ST_IDLE : ST_WDATA;
               end else begin
                  r_m0_ack <= 1'b1;
                  r_stat0  <= r_s_cmd ? ST_IDLE : ST_WDATA;
               end
               r_state <= r_s_cmd ? IDLE : RDWAIT;
            end
            RDWAIT: if (w_data_read) begin
               if (r_gnt) r_stat1 <= ST_IDLE;
               else       r_stat0 <= ST_IDLE;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.s_req   = r_s_req;
   assign bus.s_cmd   = r_s_cmd;
   assign bus.s_addr  = r_s_addr;
   assign bus.s_wdata = r_s_wdata;
   assign bus.m0_ack  = r_m0_ack;
   assign bus.m1_ack  = r_m1_ack;
   assign bus.stat0   = r_stat0;
   assign bus.stat1   = r_stat1;
endmodule

// File: tb/tb_slave_req_dispatcher.sv
// tb/tb_slave_req_dispatcher.sv - randomized scoreboard bench for slave_req_dispatcher
module tb_slave_req_dispatcher;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam bit S_NO = 1'b0;

   typedef struct {
      bit            m;
      bit            cmd;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } txn_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_tests = 0;
   int   n_fail = 0;

   txn_t          exp_q[$];
   bit            pend_v[2];
   bit            pend_cmd[2];
   logic [AW-1:0] pend_addr[2];
   logic [DW-1:0] pend_wdata[2];
   bit            sack_en = 1'b1;
   int            wait_cnt = 0;
`ifdef RR_ARB_EN
   bit            mdl_last = 1'b1;
   int            exp_pat[4] = '{0, 1, 0, 1};
`else
   int            exp_pat[4] = '{0, 0, 0, 0};
`endif

   always #5 clk = ~clk;

   slave_req_dispatcher_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   slave_req_dispatcher #(.ADDR_W(AW), .DATA_W(DW), .S_NO(S_NO)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   function automatic void check(string name, logic [95:0] got, logic [95:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endfunction

   function automatic bit elig(int m);
      return pend_v[m] && (pend_addr[m][AW-1] == S_NO);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int m);
      if (m == 0) begin
         bus.m0_req = pend_v[0]; bus.m0_cmd = pend_cmd[0];
         bus.m0_addr = pend_addr[0]; bus.m0_wdata = pend_wdata[0];
      end else begin
         bus.m1_req = pend_v[1]; bus.m1_cmd = pend_cmd[1];
         bus.m1_addr = pend_addr[1]; bus.m1_wdata = pend_wdata[1];
      end
   endtask

   task automatic set_dr(input int m, input logic v);
      if (m == 0) bus.data_read0 = v;
      else        bus.data_read1 = v;
   endtask

   task automatic new_req(input int m, input bit force_wr);
      pend_v[m]     = 1'b1;
      pend_cmd[m]   = force_wr ? 1'b1 : 1'($urandom_range(0, 1));
      pend_addr[m]  = $urandom();
      pend_addr[m][AW-1] = (force_wr || $urandom_range(0, 5) != 0) ? S_NO : ~S_NO;
      pend_wdata[m] = $urandom();
      drive(m);
   endtask

   task automatic finish_txn(input int w, input bit cmd, output int got);
      got = -1;
      for (int i = 0; i < 60 && got < 0; i++) begin
         step();
         if (bus.m0_ack || bus.m1_ack) got = bus.m1_ack ? 1 : 0;
         else if (bus.s_req && pend_v[w] && $urandom_range(0, 7) == 0) begin
            pend_v[w] = 1'b0;
            drive(w);
         end
      end
      check("ack_seen", 96'(got >= 0), 96'd1);
      pend_v[w] = 1'b0;
      drive(w);
      if (!cmd && got >= 0) begin
         repeat ($urandom_range(0, 3)) step();
         if ($urandom_range(0, 1) == 1) begin
            set_dr(1 - w, 1'b1); step(); set_dr(1 - w, 1'b0);
         end
         set_dr(w, 1'b1); step(); set_dr(w, 1'b0);
      end
   endtask

   task automatic run_round(input bit force_both, input bit no_new, output int got);
      bit   e0, e1;
      int   w;
      txn_t t;
      got = -1;
      if (!no_new)
         for (int m = 0; m < 2; m++)
            if (!pend_v[m] && (force_both || $urandom_range(0, 3) != 0)) new_req(m, force_both);
      e0 = elig(0);
      e1 = elig(1);
      if (!e0 && !e1) begin
         for (int i = 0; i < 3; i++) begin
            step();
            check("idle_no_sreq", 96'(bus.s_req), 96'd0);
            check("idle_no_ack_stat", 96'({bus.m0_ack, bus.m1_ack, bus.stat0, bus.stat1}), 96'd0);
         end
         for (int m = 0; m < 2; m++) begin pend_v[m] = 1'b0; drive(m); end
         return;
      end
      if (e0 && e1) begin
`ifdef RR_ARB_EN
         w = mdl_last ? 0 : 1;
`else
         w = 0;
`endif
      end else begin
         w = e1 ? 1 : 0;
      end
`ifdef RR_ARB_EN
      mdl_last = 1'(w);
`endif
      t.m = 1'(w); t.cmd = pend_cmd[w]; t.addr = pend_addr[w]; t.wdata = pend_wdata[w];
      exp_q.push_back(t);
      finish_txn(w, t.cmd, got);
      for (int m = 0; m < 2; m++)
         if (pend_v[m] && !elig(m) && $urandom_range(0, 1) == 1) begin pend_v[m] = 1'b0; drive(m); end
   endtask

   // Slave side: acks after a random delay, plus stray acks while no request is up.
   initial begin : slave_model
      bus.s_ack = 1'b0;
      forever begin
         step();
         if (bus.s_ack) bus.s_ack = 1'b0;
         else if (sack_en) begin
            if (bus.s_req) begin
               if (wait_cnt == 0) begin bus.s_ack = 1'b1; wait_cnt = $urandom_range(0, 3); end
               else wait_cnt--;
            end else if ($urandom_range(0, 9) == 0) bus.s_ack = 1'b1;
         end
      end
   end

   // Scoreboard: tracks the transaction phase from sampled inputs, checks outputs each cycle.
   initial begin : monitor
      int         phase;
      bit         ack_due;
      txn_t       cur;
      logic [1:0] st_exp;
      phase = 0; ack_due = 1'b0;
      cur.m = 1'b0; cur.cmd = 1'b0; cur.addr = '0; cur.wdata = '0;
      forever begin
         @(posedge clk);
         ack_due = 1'b0;
         if (reset) phase = 0;
         else if (phase == 1) begin
            if (bus.s_ack) begin ack_due = 1'b1; phase = cur.cmd ? 0 : 2; end
         end else if (phase == 2) begin
            if (cur.m ? bus.data_read1 : bus.data_read0) phase = 0;
         end else if ((bus.m0_req && bus.m0_addr[AW-1] == S_NO) ||
                      (bus.m1_req && bus.m1_addr[AW-1] == S_NO)) begin
            check("grant_queued", 96'(exp_q.size() != 0), 96'd1);
            if (exp_q.size() != 0) cur = exp_q.pop_front();
            phase = 1;
         end
         @(negedge clk);
         if (reset) begin
            phase = 0; ack_due = 1'b0;
            check("reset_outputs", {bus.s_req, bus.s_cmd, bus.s_addr, bus.s_wdata, bus.m0_ack,
                  bus.m1_ack, bus.stat0, bus.stat1}, 96'd0);
         end else begin
            st_exp = (phase == 1) ? 2'd1 : (phase == 2) ? 2'd3 : 2'd0;
            check("s_req", 96'(bus.s_req), 96'(phase == 1));
            if (phase == 1)
               check("s_fields", {bus.s_cmd, bus.s_addr, bus.s_wdata}, {cur.cmd, cur.addr, cur.wdata});
            check("stat0", 96'(bus.stat0), 96'((phase != 0 && !cur.m) ? st_exp : 2'd0));
            check("stat1", 96'(bus.stat1), 96'((phase != 0 && cur.m) ? st_exp : 2'd0));
            check("m0_ack", 96'(bus.m0_ack), 96'(ack_due && !cur.m));
            check("m1_ack", 96'(bus.m1_ack), 96'(ack_due && cur.m));
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int   got;
      txn_t t;
      bus.data_read0 = 1'b0;
      bus.data_read1 = 1'b0;
      for (int m = 0; m < 2; m++) begin
         pend_v[m] = 1'b0; pend_cmd[m] = 1'b0; pend_addr[m] = '0; pend_wdata[m] = '0;
         drive(m);
      end
      repeat (2) @(negedge clk);
      check("rst_state", {bus.s_req, bus.s_cmd, bus.s_addr, bus.s_wdata, bus.m0_ack, bus.m1_ack,
            bus.stat0, bus.stat1}, 96'd0);
      #3 reset = 1'b0;
      step();

      // Request addressed to the other slave is never served.
      pend_v[0] = 1'b1; pend_cmd[0] = 1'b1; pend_addr[0] = 32'h8000_0000; pend_wdata[0] = $urandom();
      drive(0);
      run_round(1'b0, 1'b1, got);

      // Four rounds of simultaneous writes from both masters.
      for (int r = 0; r < 4; r++) begin
         run_round(1'b1, 1'b0, got);
         check("contention_winner", 96'(got), 96'(exp_pat[r]));
      end

      for (int r = 0; r < 150; r++) run_round(1'b0, 1'b0, got);
      for (int m = 0; m < 2; m++) begin pend_v[m] = 1'b0; drive(m); end
      step();

      // Reset while the slave request is outstanding, then the same request again.
      pend_v[0] = 1'b1; pend_cmd[0] = 1'b1; pend_addr[0] = 32'h0000_0010; pend_wdata[0] = 32'hDEAD_BEEF;
      drive(0);
      sack_en = 1'b0;
      t.m = 1'b0; t.cmd = 1'b1; t.addr = 32'h0000_0010; t.wdata = 32'hDEAD_BEEF;
      exp_q.push_back(t);
      for (int i = 0; i < 10 && !bus.s_req; i++) step();
      check("pre_reset_sreq", 96'(bus.s_req), 96'd1);
      @(negedge clk);
      #2 reset = 1'b1;
      #1 check("async_reset", {bus.s_req, bus.s_cmd, bus.s_addr, bus.s_wdata, bus.m0_ack, bus.m1_ack,
               bus.stat0, bus.stat1}, 96'd0);
      exp_q.push_back(t);
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      sack_en = 1'b1;
      step();
      finish_txn(0, 1'b1, got);
      check("regrant_after_reset", 96'(got), 96'd0);
`ifdef RR_ARB_EN
      mdl_last = 1'b0;
`endif

      for (int r = 0; r < 20; r++) run_round(1'b0, 1'b0, got);
      for (int m = 0; m < 2; m++) begin pend_v[m] = 1'b0; drive(m); end
      repeat (3) step();
      check("queue_drained", 96'(exp_q.size()), 96'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
